// File: rtl/sim_console_ctrl_pkg.sv
// Shared definitions for the debug console: register offsets, STATUS bit layout and FSM states.
// STATUS packs the flags into the low byte (empty at bit 0) and the FIFO level from bit 8 upward.
package sim_console_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_CYCLES = 3'd1;
  localparam logic [2:0] OFF_INSTRS = 3'd2;
  localparam logic [2:0] OFF_STDOUT = 3'd6;
  localparam logic [2:0] OFF_HALT   = 3'd7;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_DRAINING = 2;
  localparam int STAT_HALTED   = 3;
  localparam int STAT_OVERFLOW = 4;
  localparam int STAT_LEVEL    = 8;

endpackage

// File: rtl/sim_console_ctrl_if.sv
// CPU data-bus slice, STDOUT stream and halt outputs of the debug console.
// master = CPU/stream-sink side, slave = the console itself.
interface sim_console_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_wr;
  logic              i_rd;
  logic              o_sel;
  logic              o_stall;
  logic [DATA_W-1:0] o_rdata;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_halt;
  logic [DATA_W-1:0] o_halt_code;

  modport master (
    output i_addr, i_wdata, i_wr, i_rd, i_tx_ready,
    input  o_sel, o_stall, o_rdata, o_tx_data, o_tx_valid, o_halt, o_halt_code
  );

  modport slave (
    input  i_addr, i_wdata, i_wr, i_rd, i_tx_ready,
    output o_sel, o_stall, o_rdata, o_tx_data, o_tx_valid, o_halt, o_halt_code
  );

endinterface

// File: rtl/sim_console_fifo.sv
// Synchronous FIFO, DATA_W x DEPTH (power of two), show-ahead head word.
// Callers only push when not full (or popping) and only pop when not empty.
module sim_console_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DATA_W-1:0]      i_wdata,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({i_push, i_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; a slot is only read after it was written.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = (level_q == (PTR_W+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;

endmodule

// File: rtl/sim_console_ctrl.sv
// Memory-mapped debug console: STDOUT FIFO drained over valid/ready, HALT with drain-before-halt.
// Optional perf counters (CYCLES/INSTRS) are built only when SIM_CONSOLE_PERF_EN is defined.
module sim_console_ctrl
  import sim_console_ctrl_pkg::*;
#(
  parameter int              ADDR_W     = 24,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'hFFFFF8,
  parameter int              FIFO_DEPTH = 16,
  parameter int              FULL_MODE  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_instr_valid,
  sim_console_ctrl_if.slave bus
);

  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;
  localparam bit DROP_ON_FULL = (FULL_MODE != 0);

  state_e            state_q, state_d;
  logic [2:0]        offset;
  logic              sel, stdout_wr, halt_wr, in_run, draining, halted;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, space;
  logic [LVL_W-1:0]  fifo_level;
  logic [DATA_W-1:0] fifo_head;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] halt_code_q, halt_code_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] status_word;

  // Address decode and write qualification
  assign offset    = bus.i_addr[2:0];
  assign sel       = (bus.i_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
  assign stdout_wr = sel & bus.i_wr & (offset == OFF_STDOUT);
  assign halt_wr   = sel & bus.i_wr & (offset == OFF_HALT);
  assign in_run    = (state_q == ST_RUN);

  // A pop in the same cycle frees a slot for a write to a full FIFO.
  assign fifo_pop  = i_clk_en & ~fifo_empty & bus.i_tx_ready;
  assign space     = ~fifo_full | fifo_pop;
  assign fifo_push = i_clk_en & in_run & stdout_wr & space;

  assign bus.o_stall = ~DROP_ON_FULL & in_run & stdout_wr & ~space;
  assign overflow_d  = overflow_q | (DROP_ON_FULL & i_clk_en & in_run & stdout_wr & ~space);
  assign halt_code_d = (i_clk_en & in_run & halt_wr) ? bus.i_wdata : halt_code_q;

  sim_console_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_wdata (bus.i_wdata),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (i_clk_en) begin
      case (state_q)
        ST_RUN:    if (halt_wr)    state_d = ST_DRAIN;
        ST_DRAIN:  if (fifo_empty) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    draining = (state_q == ST_DRAIN);
    halted   = (state_q == ST_HALTED);
  end

`ifdef SIM_CONSOLE_PERF_EN
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] instrs_q, instrs_d;

  // Counters freeze as soon as the HALT write leaves RUN.
  always_comb begin
    cycles_d = cycles_q;
    instrs_d = instrs_q;
    if (i_clk_en && in_run) begin
      cycles_d = cycles_q + 32'd1;
      if (i_instr_valid) instrs_d = instrs_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycles_q <= '0;
      instrs_q <= '0;
    end else begin
      cycles_q <= cycles_d;
      instrs_q <= instrs_d;
    end
  end
`else
  logic perf_unused;
  assign perf_unused = i_instr_valid;
`endif

  always_comb begin
    status_word                          = '0;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_DRAINING]           = draining;
    status_word[STAT_HALTED]             = halted;
    status_word[STAT_OVERFLOW]           = overflow_q;
    status_word[STAT_LEVEL +: LVL_W]     = fifo_level;
  end

  // Read data is captured one enabled cycle after the strobe and held otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (i_clk_en && bus.i_rd && sel) begin
      case (offset)
        OFF_STATUS: rdata_d = status_word;
`ifdef SIM_CONSOLE_PERF_EN
        OFF_CYCLES: rdata_d = DATA_W'(cycles_q);
        OFF_INSTRS: rdata_d = DATA_W'(instrs_q);
`endif
        default:    rdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      halt_code_q <= '0;
    end else begin
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign bus.o_sel       = sel;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_tx_data   = fifo_head;
  assign bus.o_tx_valid  = ~fifo_empty;
  assign bus.o_halt      = halted;
  assign bus.o_halt_code = halt_code_q;

endmodule
